// File: rtl/ssd_pkg.sv
// Shared widths, default code range and key-event encoding for the count generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssd_pkg;

  localparam int CODE_W       = 4;
  localparam int MAX_CODE_DEF = 10;

  // One decoded key action per cycle, after priority resolution
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_UP   = 2'd1,
    EV_DN   = 2'd2,
    EV_CLR  = 2'd3
  } key_ev_t;

endpackage

// File: rtl/ssd_key_debounce.sv
// One push-button: 2-flop synchronizer, debounce counter, press-edge detector.
// Latency: press_o pulses DEBOUNCE_CYCLES+2 edges after the first edge that samples a stable new level.
// Backpressure: none; the pulse is one cycle wide and is not held.
module ssd_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Synchronizer: the raw pin only ever reaches sync1_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronized key disagrees with the debounced level;
  // any agreement restarts the window. A full window flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Only released->pressed transitions are events; a held key gives one pulse
    press_d = level_q & ~level_d;
  end

  // Debounce state and registered press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ssd_count_gen.sv
// Debounced up/down/clear counter producing a 0..MAX_CODE code for a 7-segment decoder.
// Latency: count/upd/wrap change DEBOUNCE_CYCLES+3 edges after a stable raw press is first sampled.
// Backpressure: none; events while en=0 are dropped, never queued.
module ssd_count_gen
  import ssd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_CODE        = MAX_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up_n,
  input  logic              key_dn_n,
  input  logic              key_clr_n,
  input  logic              en,
  output logic [CODE_W-1:0] count,
  output logic              upd,
  output logic              wrap
);

  localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_CODE);

  logic              up_p, dn_p, clr_p;
  key_ev_t           ev;
  logic [CODE_W-1:0] count_q, count_d;
  logic              upd_q, upd_d;
  logic              wrap_q, wrap_d;

  ssd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_up_n), .press_o(up_p)
  );
  ssd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_dn_n), .press_o(dn_p)
  );
  ssd_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_clr_n), .press_o(clr_p)
  );

  // Resolve simultaneous presses: clear wins, up+dn cancel, then up, then dn
  always_comb begin
    ev = EV_NONE;
    if (clr_p)             ev = EV_CLR;
    else if (up_p && !dn_p) ev = EV_UP;
    else if (dn_p && !up_p) ev = EV_DN;
    if (!en) ev = EV_NONE;
  end

  // Next count with explicit end-of-range compares so the code never leaves 0..MAX_CODE
  always_comb begin
    count_d = count_q;
    upd_d   = 1'b0;
    wrap_d  = 1'b0;
    unique case (ev)
      EV_CLR: begin
        count_d = '0;
        upd_d   = 1'b1;
      end
      EV_UP: begin
        upd_d = 1'b1;
        if (count_q >= MAX_C) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CODE_W'(1);
        end
      end
      EV_DN: begin
        upd_d = 1'b1;
        if (count_q == '0) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - CODE_W'(1);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      upd_q   <= upd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign upd   = upd_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ssd_count_gen.sv
// Directed stimulus for ssd_count_gen with a queue scoreboard and an independent update monitor.
// Latency: expected updates may carry an exact cycle stamp to pin the debounce delay.
// Backpressure: n/a.
module tb_ssd_count_gen;

  localparam int DB  = 8;
  localparam int MAX = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_up_n, key_dn_n, key_clr_n, en;
  logic [3:0] count;
  logic       upd, wrap;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cnt;
    bit wr;
    int at;   // exact cycle of the update, or -1 for any
  } exp_t;

  exp_t q[$];
  exp_t e;

  ssd_count_gen #(.DEBOUNCE_CYCLES(DB), .MAX_CODE(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_up_n(key_up_n), .key_dn_n(key_dn_n), .key_clr_n(key_clr_n),
    .en(en), .count(count), .upd(upd), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every update the DUT presents must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && upd) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_upd: count=%0d wrap=%0b cyc=%0d, no update expected", count, wrap, cyc);
      end else begin
        e = q.pop_front();
        if (count !== e.cnt[3:0] || wrap !== e.wr || (e.at >= 0 && cyc != e.at)) begin
          errors++;
          $display("FAIL upd_value: got count=%0d wrap=%0b cyc=%0d, want count=%0d wrap=%0b cyc=%0d",
                   count, wrap, cyc, e.cnt, e.wr, e.at);
        end
      end
    end
    if (rst_n && wrap && !upd) begin
      checks++;
      errors++;
      $display("FAIL wrap_without_upd: wrap=1 upd=0 at cyc=%0d, want wrap only with upd", cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_upd(input int c, input bit w, input int at);
    exp_t x;
    x.cnt = c;
    x.wr  = w;
    x.at  = at;
    q.push_back(x);
  endtask

  // Clean press: selected keys low for 20 cycles, then released long enough to settle
  task automatic press(input bit u, input bit d, input bit c);
    if (u) key_up_n  = 1'b0;
    if (d) key_dn_n  = 1'b0;
    if (c) key_clr_n = 1'b0;
    wait_cyc(20);
    key_up_n  = 1'b1;
    key_dn_n  = 1'b1;
    key_clr_n = 1'b1;
    wait_cyc(20);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_up_n  = 1'b1;
    key_dn_n  = 1'b1;
    key_clr_n = 1'b1;
    en        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_upd", int'(upd), 0);
    chk("reset_wrap", int'(wrap), 0);

    // Key held from reset release: first sample next edge, update 11 edges later
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    key_up_n = 1'b0;
    expect_upd(1, 1'b0, cyc + 1 + DB + 3);
    wait_cyc(20);
    key_up_n = 1'b1;
    wait_cyc(20);

    // Bounce shorter than the debounce window: no event
    key_up_n = 1'b0; wait_cyc(3);
    key_up_n = 1'b1; wait_cyc(2);
    key_up_n = 1'b0; wait_cyc(3);
    key_up_n = 1'b1; wait_cyc(20);
    chk("bounce_count", int'(count), 1);

    // Clear, then eleven ups walk 1..10 and wrap to 0
    expect_upd(0, 1'b0, -1);
    press(0, 0, 1);
    for (int i = 1; i <= 11; i++) begin
      expect_upd((i <= MAX) ? i : 0, i > MAX, -1);
      press(1, 0, 0);
    end
    chk("after_11_ups", int'(count), 0);

    // Down at 0 wraps to MAX
    expect_upd(MAX, 1'b1, -1);
    press(0, 1, 0);
    chk("dn_wrap_count", int'(count), MAX);

    // Reach 5, then up+dn together changes nothing
    expect_upd(0, 1'b0, -1);
    press(0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      expect_upd(i, 1'b0, -1);
      press(1, 0, 0);
    end
    press(1, 1, 0);
    chk("up_dn_cancel", int'(count), 5);

    // Reach 7, then clr+up together: clear wins
    expect_upd(6, 1'b0, -1);
    press(1, 0, 0);
    expect_upd(7, 1'b0, -1);
    press(1, 0, 0);
    expect_upd(0, 1'b0, -1);
    press(1, 0, 1);
    chk("clr_wins", int'(count), 0);

    // Press while disabled is dropped, not replayed when enable returns
    en = 1'b0;
    press(1, 0, 0);
    en = 1'b1;
    wait_cyc(10);
    chk("en_drop", int'(count), 0);

    // Move off zero so the reset clear is visible
    expect_upd(1, 1'b0, -1);
    press(1, 0, 0);
    chk("pre_reset_count", int'(count), 1);

    // Reset mid-debounce with dn held: partial count lost, one decrement after full time
    key_dn_n = 1'b0;
    wait_cyc(5);
    rst_n = 1'b0;
    #2;
    chk("async_reset_count", int'(count), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    expect_upd(MAX, 1'b1, cyc + 1 + DB + 3);
    wait_cyc(25);
    key_dn_n = 1'b1;
    wait_cyc(20);
    chk("post_reset_dn", int'(count), MAX);

    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
